pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised pipeline stage register: the general successor to the fixed-width
//  IF/ID and ID/EX registers. Carries a control field and a data field under a
//  valid/ready handshake, with hazard bubble insertion, flush and an optional
//  2-entry skid buffer. Sits between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
// PARAMETERS
//  CTRL_W  13   width of control field; zeroed on bubble or flush
//  DATA_W  160  width of data field (PC, operands, imm, rd/rs1/rs2, PC+4)
//  SKID    1    1 = 2-entry skid buffer, registered in_ready; 0 = single register
//  CNT_W   16   width of bubble/flush statistic counters
// PORTS
//  clk        in   1       stage clock, rising edge
//  rst        in   1       asynchronous reset, active low
//  in_valid   in   1       upstream entry present
//  in_ready   out  1       stage accepts entry this cycle
//  in_ctrl    in   CTRL_W  upstream control bits
//  in_data    in   DATA_W  upstream data bits
//  bubble     in   1       hazard: accepted entry has ctrl forced to 0 (NOP)
//  flush      in   1       kill all held entries (branch/jump redirect)
//  out_valid  out  1       entry presented downstream
//  out_ready  in   1       downstream consumes entry
//  out_ctrl   out  CTRL_W  presented control bits
//  out_data   out  DATA_W  presented data bits
//  occupancy  out  2       held entries (0..2; max 1 when SKID=0)
//  bubble_cnt out  CNT_W   accepted bubbles, saturating
//  flush_cnt  out  CNT_W   flush events that killed >=1 valid entry, saturating
// BEHAVIOUR
//  - rst low: out_valid, out_ctrl, out_data, occupancy, both counters = 0;
//    in_ready = 1 (SKID=1 registered value; SKID=0 follows from out_valid=0).
//  - accept = in_valid & in_ready; consume = out_valid & out_ready; both on clk rise.
//  - bubble applies only to accepted entry: ctrl stored as 0, data stored as-is,
//    valid stored 1 (NOP advances through pipe). bubble without accept: no effect.
//  - SKID=0: in_ready = out_ready | ~out_valid (combinational). Latency 1 cycle.
//  - SKID=1 states (occupancy): EMPTY(0), ONE(1), FULL(2: main + skid).
//    EMPTY: accept -> ONE (entry into main).
//    ONE:   accept&consume -> ONE (new entry replaces main); accept only -> FULL
//           (entry into skid); consume only -> EMPTY.
//    FULL:  in_ready=0; consume -> ONE (skid moves to main, skid cleared).
//    in_ready registered = (next occupancy < 2); no comb path out_ready->in_ready.
//    Latency 1 cycle from accept to out_valid when EMPTY; order strictly FIFO.
//  - flush: highest priority. Next edge: occupancy=0, out_valid=0, out_ctrl=0,
//    out_data=0, skid cleared; entry offered same cycle discarded even if
//    in_ready=1. consume in flush cycle still counts downstream (output was valid).
//  - out_ctrl/out_data stable while out_valid & ~out_ready (no change under stall).
//  - Counters saturate at 2^CNT_W-1, never wrap; bubble_cnt +1 per accepted bubble
//    (not when flush same cycle); flush_cnt +1 only if occupancy>0 at flush.
//  - Reset mid-operation: all state cleared immediately; held entries lost.
//  - out_valid=0 implies out_ctrl=0 (dead slots never carry write/mem enables).
// TESTING
//  1 Reset: rst=0 with in_valid=1 -> out_valid=0, occupancy=0, in_ready=1,
//    counters=0; release rst, in_data=0x..A5, ctrl=13'h1FFF -> next cycle out matches.
//  2 Stream: out_ready=1, 8 back-to-back entries data=1..8 -> outputs 1..8 on
//    consecutive cycles, occupancy stays 1, in_ready never drops.
//  3 Back-pressure (SKID=1): out_ready=0, send A,B,C -> A,B held, occupancy=2,
//    in_ready=0, C stalls upstream; out_ready=1 -> A,B,C emerge in order, none lost.
//  4 Bubble: accept ctrl=13'h1ABC data=0x77 with bubble=1 -> out_valid=1,
//    out_ctrl=0, out_data=0x77, bubble_cnt=1.
//  5 Flush: occupancy=2, flush=1 with in_valid=1 -> next cycle occupancy=0,
//    out_valid=0, out_ctrl=0, flush_cnt=1; flush on empty stage -> flush_cnt unchanged.
//  6 Saturation: CNT_W=2, 5 accepted bubbles -> bubble_cnt=3 and holds.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, bubble insertion, flush,
// an optional 2-entry skid buffer and saturating bubble/flush statistics.
module pipe_stage_skid #(
    parameter int CTRL_W = 13,
    parameter int DATA_W = 160,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_bubble,
    input  logic              i_flush,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CTRL_W-1:0] o_out_ctrl,
    output logic [DATA_W-1:0] o_out_data,
    output logic [1:0]        o_occupancy,
    output logic [CNT_W-1:0]  o_bubble_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    logic              w_accept;
    logic              w_consume;
    logic              w_in_ready;
    logic              w_out_valid;
    logic [1:0]        w_occupancy;
    logic [CTRL_W-1:0] w_in_ctrl;
    logic [CTRL_W-1:0] w_out_ctrl;
    logic [DATA_W-1:0] w_out_data;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    assign w_accept  = i_in_valid & w_in_ready;
    assign w_consume = w_out_valid & i_out_ready;
    // A bubble turns the accepted entry into a NOP that still advances.
    assign w_in_ctrl = i_bubble ? '0 : i_in_ctrl;

    generate
        if (SKID != 0) begin : g_skid
            state_t            r_state;
            state_t            w_state_nxt;
            logic              r_in_ready;
            logic [CTRL_W-1:0] r_main_ctrl;
            logic [DATA_W-1:0] r_main_data;
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;
            logic              w_main_load;
            logic              w_main_shift;
            logic              w_main_clr;
            logic              w_skid_load;
            logic              w_skid_clr;

            always_comb begin
                // NOTE: every output gets a default first, so no path can infer a latch.
                w_state_nxt  = r_state;
                w_main_load  = 1'b0;
                w_main_shift = 1'b0;
                w_main_clr   = 1'b0;
                w_skid_load  = 1'b0;
                w_skid_clr   = 1'b0;
                if (i_flush) begin
                    w_state_nxt = ST_EMPTY;
                    w_main_clr  = 1'b1;
                    w_skid_clr  = 1'b1;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_accept) begin
                                w_main_load = 1'b1;
                                w_state_nxt = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (w_accept && w_consume) begin
                                w_main_load = 1'b1;
                            end else if (w_accept) begin
                                w_skid_load = 1'b1;
                                w_state_nxt = ST_FULL;
                            end else if (w_consume) begin
                                w_main_clr  = 1'b1;
                                w_state_nxt = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (w_consume) begin
                                w_main_shift = 1'b1;
                                w_skid_clr   = 1'b1;
                                w_state_nxt  = ST_ONE;
                            end
                        end
                        default: begin
                            w_main_clr  = 1'b1;
                            w_skid_clr  = 1'b1;
                            w_state_nxt = ST_EMPTY;
                        end
                    endcase
                end
            end

            // NOTE: sequential state is updated with non-blocking assignments only.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_state    <= ST_EMPTY;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_nxt;
                    r_in_ready <= (w_state_nxt != ST_FULL);
                end
            end

            // NOTE: entry registers are reset because outputs must read zero during reset.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_main_ctrl <= '0;
                    r_main_data <= '0;
                    r_skid_ctrl <= '0;
                    r_skid_data <= '0;
                end else begin
                    if (w_main_clr) begin
                        r_main_ctrl <= '0;
                        r_main_data <= '0;
                    end else if (w_main_load) begin
                        r_main_ctrl <= w_in_ctrl;
                        r_main_data <= i_in_data;
                    end else if (w_main_shift) begin
                        r_main_ctrl <= r_skid_ctrl;
                        r_main_data <= r_skid_data;
                    end
                    if (w_skid_clr) begin
                        r_skid_ctrl <= '0;
                        r_skid_data <= '0;
                    end else if (w_skid_load) begin
                        r_skid_ctrl <= w_in_ctrl;
                        r_skid_data <= i_in_data;
                    end
                end
            end

            assign w_in_ready  = r_in_ready;
            assign w_out_valid = (r_state != ST_EMPTY);
            assign w_occupancy = r_state;
            assign w_out_ctrl  = r_main_ctrl;
            assign w_out_data  = r_main_data;
        end else begin : g_single
            logic              r_valid;
            logic [CTRL_W-1:0] r_ctrl;
            logic [DATA_W-1:0] r_data;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                    r_data  <= '0;
                end else if (i_flush) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                    r_data  <= '0;
                end else if (w_accept) begin
                    r_valid <= 1'b1;
                    r_ctrl  <= w_in_ctrl;
                    r_data  <= i_in_data;
                end else if (w_consume) begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                end
            end

            assign w_in_ready  = i_out_ready | ~r_valid;
            assign w_out_valid = r_valid;
            assign w_occupancy = {1'b0, r_valid};
            assign w_out_ctrl  = r_ctrl;
            assign w_out_data  = r_data;
        end
    endgenerate

    // Statistics saturate at all-ones; flushes only count when they kill something.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (w_accept && i_bubble && !i_flush && (r_bubble_cnt != '1))
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            if (i_flush && (w_occupancy != 2'd0) && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign o_in_ready   = w_in_ready;
    assign o_out_valid  = w_out_valid;
    assign o_out_ctrl   = w_out_ctrl;
    assign o_out_data   = w_out_data;
    assign o_occupancy  = w_occupancy;
    assign o_bubble_cnt = r_bubble_cnt;
    assign o_flush_cnt  = r_flush_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid variant (CNT_W=16) and a single-register
// variant (CNT_W=2) driven by the same stimulus.
module tb_pipe_stage_skid;

    localparam int CTRL_W = 13;
    localparam int DATA_W = 160;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              bubble;
    logic              flush;
    logic              out_ready;

    logic              s_in_ready, s_out_valid;
    logic [CTRL_W-1:0] s_out_ctrl;
    logic [DATA_W-1:0] s_out_data;
    logic [1:0]        s_occ;
    logic [15:0]       s_bcnt, s_fcnt;

    logic              r_in_ready, r_out_valid;
    logic [CTRL_W-1:0] r_out_ctrl;
    logic [DATA_W-1:0] r_out_data;
    logic [1:0]        r_occ;
    logic [1:0]        r_bcnt, r_fcnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .rst(rst), .i_in_valid(in_valid), .o_in_ready(s_in_ready),
        .i_in_ctrl(in_ctrl), .i_in_data(in_data), .i_bubble(bubble), .i_flush(flush),
        .o_out_valid(s_out_valid), .i_out_ready(out_ready), .o_out_ctrl(s_out_ctrl),
        .o_out_data(s_out_data), .o_occupancy(s_occ), .o_bubble_cnt(s_bcnt),
        .o_flush_cnt(s_fcnt)
    );

    pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(2)) u_reg (
        .clk(clk), .rst(rst), .i_in_valid(in_valid), .o_in_ready(r_in_ready),
        .i_in_ctrl(in_ctrl), .i_in_data(in_data), .i_bubble(bubble), .i_flush(flush),
        .o_out_valid(r_out_valid), .i_out_ready(out_ready), .o_out_ctrl(r_out_ctrl),
        .o_out_data(r_out_data), .o_occupancy(r_occ), .o_bubble_cnt(r_bcnt),
        .o_flush_cnt(r_fcnt)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 13'h1FFF;
        in_data   = 160'hA5;
        bubble    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset held with an entry offered: nothing may be accepted.
        step();
        step();
        check("rst_out_valid", s_out_valid, 0);
        check("rst_occ", s_occ, 0);
        check("rst_in_ready", s_in_ready, 1);
        check("rst_out_ctrl", s_out_ctrl, 0);
        check("rst_out_data", s_out_data, 0);
        check("rst_bcnt", s_bcnt, 0);
        check("rst_fcnt", s_fcnt, 0);
        check("rst_reg_in_ready", r_in_ready, 1);

        rst = 1'b1;
        step();
        check("first_out_valid", s_out_valid, 1);
        check("first_out_ctrl", s_out_ctrl, 13'h1FFF);
        check("first_out_data", s_out_data, 160'hA5);
        check("first_reg_out_data", r_out_data, 160'hA5);

        // Streaming: one entry in, one entry out every cycle.
        for (int i = 1; i <= 8; i++) begin
            in_data = DATA_W'(i);
            in_ctrl = CTRL_W'(i);
            step();
            check("stream_data", s_out_data, DATA_W'(i));
            check("stream_occ", s_occ, 1);
            check("stream_in_ready", s_in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("drain_out_valid", s_out_valid, 0);
        check("drain_out_ctrl", s_out_ctrl, 0);

        // Back-pressure: A and B fill main+skid, C stalls upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 13'h00A;
        in_data   = 160'hA;
        step();
        check("bp_occ_one", s_occ, 1);
        check("bp_ready_one", s_in_ready, 1);
        in_ctrl = 13'h00B;
        in_data = 160'hB;
        step();
        check("bp_occ_full", s_occ, 2);
        check("bp_ready_full", s_in_ready, 0);
        check("bp_head_a", s_out_data, 160'hA);
        in_ctrl = 13'h00C;
        in_data = 160'hC;
        step();
        check("bp_stall_occ", s_occ, 2);
        check("bp_stall_data", s_out_data, 160'hA);
        check("bp_stall_ctrl", s_out_ctrl, 13'h00A);
        check("bp_reg_in_ready", r_in_ready, 0);
        out_ready = 1'b1;
        step();
        check("bp_out_b", s_out_data, 160'hB);
        check("bp_ready_again", s_in_ready, 1);
        step();
        check("bp_out_c", s_out_data, 160'hC);
        check("bp_out_c_ctrl", s_out_ctrl, 13'h00C);
        in_valid = 1'b0;
        step();
        check("bp_empty", s_out_valid, 0);

        // Bubble: entry accepted as a NOP, data kept.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 13'h1ABC;
        in_data   = 160'h77;
        bubble    = 1'b1;
        step();
        check("bub_out_valid", s_out_valid, 1);
        check("bub_out_ctrl", s_out_ctrl, 0);
        check("bub_out_data", s_out_data, 160'h77);
        check("bub_cnt", s_bcnt, 1);
        bubble = 1'b0;

        // Flush with both slots held and an entry offered.
        in_ctrl = 13'h0005;
        in_data = 160'h55;
        step();
        check("fl_occ_full", s_occ, 2);
        flush   = 1'b1;
        in_ctrl = 13'h0006;
        in_data = 160'h66;
        step();
        check("fl_occ", s_occ, 0);
        check("fl_out_valid", s_out_valid, 0);
        check("fl_out_ctrl", s_out_ctrl, 0);
        check("fl_out_data", s_out_data, 0);
        check("fl_cnt", s_fcnt, 1);
        check("fl_in_ready", s_in_ready, 1);
        // Flush on an empty stage, with a bubble offered: neither counter moves.
        bubble = 1'b1;
        step();
        check("fl_empty_cnt", s_fcnt, 1);
        check("fl_empty_occ", s_occ, 0);
        check("fl_bub_cnt", s_bcnt, 1);
        flush  = 1'b0;
        bubble = 1'b0;
        in_valid = 1'b0;

        // Reset mid-operation clears held entries immediately.
        in_valid = 1'b1;
        step();
        check("mid_occ_before", s_occ, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_occ", s_occ, 0);
        check("mid_rst_valid", s_out_valid, 0);
        check("mid_rst_fcnt", s_fcnt, 0);
        step();
        rst = 1'b1;

        // Saturation of the 2-bit counter on the single-register variant.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        bubble    = 1'b1;
        in_ctrl   = 13'h0FFF;
        in_data   = 160'h3;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("sat_reg_bcnt", r_bcnt, (i < 3) ? i : 3);
            check("sat_skid_bcnt", s_bcnt, i);
            check("sat_reg_ctrl", r_out_ctrl, 0);
        end
        in_valid  = 1'b0;
        bubble    = 1'b0;
        out_ready = 1'b0;
        step();
        check("sat_hold", r_bcnt, 3);
        check("reg_stall_in_ready", r_in_ready, 0);
        check("reg_stall_valid", r_out_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
